// File: rtl/temporal_buffer_reader.sv
// Read-side drain sequencer for the WalkSAT temporal buffer: walks slots 0..NSAT-1,
// unpacks each entry and streams its literals one per handshake to the break-value unit.
module temporal_buffer_reader #(
    parameter  int NSAT       = 3,
    parameter  int LAW        = 12,
    parameter  int SIZE       = 2,
    parameter  int SKIP_ZERO  = 1,
    localparam int DATA_WIDTH = SIZE * LAW,
    localparam int NSAT_BITS  = $clog2(NSAT),
    localparam int POS_BITS   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic [NSAT_BITS-1:0]  rd_index_o,
    input  logic [DATA_WIDTH-1:0] literals_i,
    output logic                  lit_valid_o,
    input  logic                  lit_ready_i,
    output logic [LAW-1:0]        lit_o,
    output logic [NSAT_BITS-1:0]  lit_slot_o,
    output logic [POS_BITS-1:0]   lit_pos_o,
    output logic                  lit_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [NSAT_BITS-1:0] LAST_SLOT = NSAT_BITS'(NSAT - 1);
    localparam logic [POS_BITS-1:0]  LAST_POS  = POS_BITS'(SIZE - 1);

    state_e                 state_q, state_d;
    logic [NSAT_BITS-1:0]   slot_q, slot_d;
    logic [POS_BITS-1:0]    pos_q, pos_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [LAW-1:0]         cur_lit;
    logic                   skip_cur;
    logic                   emit_vld;
    logic                   advance;

    assign cur_lit  = shift_q[LAW-1:0];
    assign skip_cur = (SKIP_ZERO != 0) && (cur_lit == '0);
    assign emit_vld = (state_q == EMIT) && !skip_cur;
    // Null literals step through on their own; real ones wait for the consumer.
    assign advance  = (state_q == EMIT) && (skip_cur || lit_ready_i);

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        pos_d   = pos_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                    slot_d  = '0;
                    pos_d   = '0;
                end
            end
            FETCH: begin
                // The last slot is the bypass slot, so data is only valid in this cycle.
                shift_d = literals_i;
                pos_d   = '0;
                state_d = EMIT;
            end
            EMIT: begin
                if (advance) begin
                    shift_d = shift_q >> LAW;
                    if (pos_q == LAST_POS) begin
                        if (slot_q == LAST_SLOT) begin
                            state_d = DONE;
                        end else begin
                            slot_d  = NSAT_BITS'(slot_q + 1'b1);
                            state_d = FETCH;
                        end
                    end else begin
                        pos_d = POS_BITS'(pos_q + 1'b1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            slot_q  <= '0;
            pos_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            pos_q   <= pos_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rd_index_o  = slot_q;
    assign lit_o       = cur_lit;
    assign lit_slot_o  = slot_q;
    assign lit_pos_o   = pos_q;
    assign lit_valid_o = emit_vld;
    assign lit_last_o  = emit_vld && (slot_q == LAST_SLOT) && (pos_q == LAST_POS);
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_temporal_buffer_reader.sv
// Bench for temporal_buffer_reader: two instances (null skipping on/off) share stimulus
// and are compared cycle by cycle against a per-literal timing model of the drain.
module tb_temporal_buffer_reader;
    localparam int NSAT = 3, LAW = 12, SIZE = 2, DW = 24, NB = 2, PB = 1, MAXC = 200;

    logic clk_i = 1'b0;
    logic rst_ni, start_i, lit_ready_i;
    logic [DW-1:0] mem [NSAT];
    logic [DW-1:0] live_cur;

    logic [NB-1:0]  rd_a, slot_a, rd_b, slot_b;
    logic [DW-1:0]  lits_a, lits_b;
    logic [LAW-1:0] lit_a, lit_b;
    logic [PB-1:0]  pos_a, pos_b;
    logic val_a, last_a, busy_a, done_a, val_b, last_b, busy_b, done_b;

    always #5 clk_i = ~clk_i;

    // Behaves as the buffer: last slot returns live write data, others stored entries.
    assign lits_a = (rd_a == NB'(NSAT-1)) ? live_cur : mem[rd_a];
    assign lits_b = (rd_b == NB'(NSAT-1)) ? live_cur : mem[rd_b];

    temporal_buffer_reader #(.NSAT(NSAT), .LAW(LAW), .SIZE(SIZE), .SKIP_ZERO(1)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .rd_index_o(rd_a),
        .literals_i(lits_a), .lit_valid_o(val_a), .lit_ready_i(lit_ready_i), .lit_o(lit_a),
        .lit_slot_o(slot_a), .lit_pos_o(pos_a), .lit_last_o(last_a), .busy_o(busy_a), .done_o(done_a));

    temporal_buffer_reader #(.NSAT(NSAT), .LAW(LAW), .SIZE(SIZE), .SKIP_ZERO(0)) u_dut_noskip (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .rd_index_o(rd_b),
        .literals_i(lits_b), .lit_valid_o(val_b), .lit_ready_i(lit_ready_i), .lit_o(lit_b),
        .lit_slot_o(slot_b), .lit_pos_o(pos_b), .lit_last_o(last_b), .busy_o(busy_b), .done_o(done_b));

    typedef struct {
        logic [DW-1:0]           m0, m1, byp;
        int                      byp_cyc, pct, st_from, st_n, extra, abort_at;
        int                      exp_done, exp_n, exp_nb;
        logic [5:0][LAW-1:0]     seq;
        bit                      rnd;
    } tc_t;

    tc_t tcs [12];
    int errors = 0, checks = 0;
    bit rdy [MAXC];
    logic [DW-1:0] live [MAXC];
    logic [18:0] expv [2][MAXC];
    int exp_done [2];

    function automatic logic [18:0] pk(input logic v, input logic [LAW-1:0] l, input logic [NB-1:0] s,
                                       input logic [PB-1:0] p, input logic la, input logic d, input logic b);
        pk = v ? {1'b1, l, s, p, la, d, b} : {1'b0, 12'h000, 2'b00, 1'b0, la, d, b};
    endfunction

    task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, n, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_ent();
        logic [DW-1:0] e;
        for (int k = 0; k < SIZE; k++)
            e[k*LAW +: LAW] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
        return e;
    endfunction

    // Walk the pass literal by literal: one fetch cycle per slot, one cycle per skipped
    // null, and each real literal occupies cycles until the consumer is ready.
    task automatic build_model(input int d, input bit skip);
        int t;
        logic [DW-1:0] ent;
        logic [LAW-1:0] l;
        for (int n = 0; n < MAXC; n++) expv[d][n] = pk(0, 0, 0, 0, 0, 0, 0);
        t = 1;
        for (int s = 0; s < NSAT; s++) begin
            expv[d][t] = pk(0, 0, 0, 0, 0, 0, 1);
            ent = (s == NSAT-1) ? live[t] : mem[s];
            t++;
            for (int p = 0; p < SIZE; p++) begin
                l = ent[p*LAW +: LAW];
                if (skip && l == 0) begin
                    expv[d][t] = pk(0, 0, 0, 0, 0, 0, 1);
                    t++;
                end else begin
                    do begin
                        expv[d][t] = pk(1, l, NB'(s), PB'(p), (s == NSAT-1) && (p == SIZE-1), 0, 1);
                        t++;
                    end while (!rdy[t-1]);
                end
            end
        end
        expv[d][t] = pk(0, 0, 0, 0, 0, 1, 1);
        exp_done[d] = t;
    endtask

    task automatic run_case(input int id);
        tc_t tc;
        int last, ndone_a, ndone_b, dcyc_a, dcyc_b, rd_bad;
        logic [LAW-1:0] obs [$];
        int nobs_b;
        tc = tcs[id];
        mem[0] = tc.rnd ? rand_ent() : tc.m0;
        mem[1] = tc.rnd ? rand_ent() : tc.m1;
        mem[2] = 0;
        for (int n = 0; n < MAXC; n++) begin
            live[n] = (n == tc.byp_cyc) ? tc.byp : (tc.rnd ? rand_ent() : DW'($urandom));
            rdy[n]  = (n >= 150) || ($urandom_range(0, 99) < tc.pct);
            if (n >= tc.st_from && n < tc.st_from + tc.st_n) rdy[n] = 0;
        end
        build_model(0, 1'b1);
        build_model(1, 1'b0);
        last = (exp_done[0] > exp_done[1] ? exp_done[0] : exp_done[1]) + 2;
        ndone_a = 0; ndone_b = 0; dcyc_a = -1; dcyc_b = -1; rd_bad = 0; nobs_b = 0;
        for (int n = 0; n <= last; n++) begin
            @(negedge clk_i);
            chk("cyc_skip", n, 32'(pk(val_a, lit_a, slot_a, pos_a, last_a, done_a, busy_a)), 32'(expv[0][n]));
            chk("cyc_noskip", n, 32'(pk(val_b, lit_b, slot_b, pos_b, last_b, done_b, busy_b)), 32'(expv[1][n]));
            if (rd_a > NB'(NSAT-1) || rd_b > NB'(NSAT-1)) rd_bad++;
            start_i     = (n == 0) || (n == tc.extra);
            lit_ready_i = rdy[n];
            live_cur    = live[n];
            if (val_a && lit_ready_i) obs.push_back(lit_a);
            if (val_b && lit_ready_i) nobs_b++;
            if (done_a) begin ndone_a++; dcyc_a = n; end
            if (done_b) begin ndone_b++; dcyc_b = n; end
            if (n == tc.abort_at) begin
                #1 rst_ni = 1'b0;
                #1;
                chk("abort_out_a", n, {rd_a, lit_a, slot_a, pos_a, val_a, last_a, busy_a, done_a}, 0);
                chk("abort_out_b", n, {rd_b, lit_b, slot_b, pos_b, val_b, last_b, busy_b, done_b}, 0);
                start_i = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk_i);
                    if (k == 2) rst_ni = 1'b1;
                    if (done_a || done_b || busy_a || busy_b || val_a || val_b) ndone_a += 100;
                end
                chk("abort_no_done", n, ndone_a + ndone_b, 0);
                return;
            end
        end
        start_i = 1'b0;
        chk("rd_range", id, rd_bad, 0);
        chk("done_once_skip", id, ndone_a, 1);
        chk("done_once_noskip", id, ndone_b, 1);
        if (tc.exp_done >= 0) begin
            chk("done_cyc_skip", id, dcyc_a, tc.exp_done);
            chk("done_cyc_noskip", id, dcyc_b, tc.exp_done);
        end
        if (tc.exp_n > 0) begin
            chk("lit_count", id, obs.size(), tc.exp_n);
            chk("lit_count_noskip", id, nobs_b, tc.exp_nb);
            for (int k = 0; k < tc.exp_n && k < obs.size(); k++)
                chk("lit_seq", k, 32'(obs[k]), 32'(tc.seq[k]));
        end
    endtask

    initial begin
        tc_t base;
        base = '{m0: 24'h00A00B, m1: 24'hABCDEF, byp: 24'h123456, byp_cyc: 7, pct: 100,
                 st_from: -1, st_n: 0, extra: -1, abort_at: -1, exp_done: 10, exp_n: 6, exp_nb: 6,
                 seq: {12'h123, 12'h456, 12'hABC, 12'hDEF, 12'h00A, 12'h00B}, rnd: 0};
        tcs[0] = base;
        tcs[1] = base; tcs[1].st_from = 5; tcs[1].st_n = 3; tcs[1].byp_cyc = 10; tcs[1].exp_done = 13;
        tcs[2] = base; tcs[2].m1 = 24'h000000; tcs[2].exp_n = 4;
        tcs[2].seq = {12'h000, 12'h000, 12'h123, 12'h456, 12'h00A, 12'h00B};
        tcs[3] = base; tcs[3].extra = 5;
        tcs[4] = base; tcs[4].abort_at = 5; tcs[4].exp_done = -1; tcs[4].exp_n = 0;
        tcs[5] = base;
        for (int i = 6; i < 12; i++) begin
            tcs[i] = base; tcs[i].rnd = 1; tcs[i].byp_cyc = -1; tcs[i].pct = 55;
            tcs[i].exp_done = -1; tcs[i].exp_n = 0;
            tcs[i].extra = (i % 2 == 0) ? int'($urandom_range(2, 8)) : -1;
        end

        mem[0] = 0; mem[1] = 0; mem[2] = 0; live_cur = 0;
        rst_ni = 1'b0; start_i = 1'b1; lit_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("reset_a", 0, {rd_a, lit_a, slot_a, pos_a, val_a, last_a, busy_a, done_a}, 0);
        chk("reset_b", 0, {rd_b, lit_b, slot_b, pos_b, val_b, last_b, busy_b, done_b}, 0);
        start_i = 1'b0;
        rst_ni  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("idle_hold", k, {busy_a, busy_b, val_a, val_b, done_a, done_b}, 0);
        end

        for (int i = 0; i < 12; i++) run_case(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
